// File: rtl/tag_sram_ctrl_pkg.sv
// Shared definitions for the tag store controller.
// Holds the default geometry, the grant encoding used by the round-robin
// arbiter, the controller state encoding, and the {valid, tag} entry layout.
package tag_sram_ctrl_pkg;

  localparam int CACHE_SET_BITS_DEFAULT = 2;
  localparam int CACHE_TAG_BITS_DEFAULT = 24;

  // Bit positions in the arbiter's req/gnt vectors.
  localparam int GNT_LK = 0;
  localparam int GNT_WR = 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entries are stored as {valid, tag}, so the valid bit sits just above the tag.
  function automatic int entry_valid_bit(input int tag_bits);
    return tag_bits;
  endfunction

endpackage

// File: rtl/tag_sram_ctrl_if.sv
// Bus bundle between the cache datapath, the tag store controller and the
// single-port tag SRAM.
//
// Handshakes: a request (lk_*, wr_*) transfers in a cycle where both valid
// and ready are high. Ready may depend combinationally on the other
// requester's valid but never on its own valid. Lookup responses have no
// ready: lk_resp_valid is a one-cycle pulse that must be consumed.
//
// Modports:
//   slave  - the controller (tag_sram_ctrl)
//   master - the cache datapath and SRAM side that surround it
interface tag_sram_ctrl_if
  import tag_sram_ctrl_pkg::*;
#(
  parameter int CACHE_SET_BITS = CACHE_SET_BITS_DEFAULT,
  parameter int CACHE_TAG_BITS = CACHE_TAG_BITS_DEFAULT
);

  logic                      lk_valid;
  logic                      lk_ready;
  logic [CACHE_SET_BITS-1:0] lk_set;
  logic [CACHE_TAG_BITS-1:0] lk_tag;
  logic                      lk_resp_valid;
  logic                      lk_hit;
  logic [CACHE_TAG_BITS-1:0] lk_resp_tag;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [CACHE_SET_BITS-1:0] wr_set;
  logic [CACHE_TAG_BITS-1:0] wr_tag;
  logic                      wr_inval;

  logic                      init_done;

  logic                      sram_we;
  logic [CACHE_SET_BITS-1:0] sram_addr;
  logic [CACHE_TAG_BITS:0]   sram_din;
  logic [CACHE_TAG_BITS:0]   sram_dout;

  modport slave (
    input  lk_valid, lk_set, lk_tag,
    input  wr_valid, wr_set, wr_tag, wr_inval,
    input  sram_dout,
    output lk_ready, lk_resp_valid, lk_hit, lk_resp_tag,
    output wr_ready, init_done,
    output sram_we, sram_addr, sram_din
  );

  modport master (
    output lk_valid, lk_set, lk_tag,
    output wr_valid, wr_set, wr_tag, wr_inval,
    output sram_dout,
    input  lk_ready, lk_resp_valid, lk_hit, lk_resp_tag,
    input  wr_ready, init_done,
    input  sram_we, sram_addr, sram_din
  );

endinterface

// File: rtl/tag_rr_arb.sv
// Two-requester round-robin arbiter for the tag SRAM port.
//
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   req[1:0]     - request per requester (GNT_LK / GNT_WR positions)
//   gnt[1:0]     - grant a requester would receive if it requested now;
//                  depends only on the other requester's req, so it can be
//                  used directly as a ready
//
// last_grant remembers who was served most recently; on contention the other
// requester wins. It resets to WR so a lookup wins the first contention.
module tag_rr_arb
  import tag_sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt         = '0;
    gnt[GNT_LK] = ~req[GNT_WR] | (last_grant == 1'(GNT_WR));
    gnt[GNT_WR] = ~req[GNT_LK] | (last_grant == 1'(GNT_LK));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'(GNT_WR);
    end else if (req[GNT_LK] && gnt[GNT_LK]) begin
      last_grant <= 1'(GNT_LK);
    end else if (req[GNT_WR] && gnt[GNT_WR]) begin
      last_grant <= 1'(GNT_WR);
    end
  end

endmodule

// File: rtl/tag_sram_ctrl.sv
// Sequencing and arbitration controller for the direct-mapped cache's
// single-port tag store.
//
// After reset it clears every entry (INIT), then shares the SRAM port between
// lookups and tag writes cycle by cycle (RUN), returning hit/miss one cycle
// after each accepted lookup.
//
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   bus          - tag_sram_ctrl_if.slave: lookup, write, init_done and SRAM
//   dbg_state    - current controller state
module tag_sram_ctrl
  import tag_sram_ctrl_pkg::*;
#(
  parameter int CACHE_SET_BITS = CACHE_SET_BITS_DEFAULT,
  parameter int CACHE_TAG_BITS = CACHE_TAG_BITS_DEFAULT
)(
  input  logic             clk,
  input  logic             reset_n,
  tag_sram_ctrl_if.slave   bus,
  output state_t           dbg_state
);

  localparam int N   = 1 << CACHE_SET_BITS;
  localparam int VLD = entry_valid_bit(CACHE_TAG_BITS);

  state_t                    state;
  // One bit wider than the set index so the terminal compare never wraps.
  logic [CACHE_SET_BITS:0]   clr_idx;
  logic                      init_done_q;
  logic                      resp_valid_q;
  logic [CACHE_TAG_BITS-1:0] lk_tag_q;
  logic [CACHE_SET_BITS-1:0] addr_q;

  logic                      run;
  logic [1:0]                req;
  logic [1:0]                gnt;
  logic                      lk_acc;
  logic                      wr_acc;

  logic                      sram_we_c;
  logic [CACHE_SET_BITS-1:0] sram_addr_c;
  logic [CACHE_TAG_BITS:0]   sram_din_c;

  assign run = (state == ST_RUN);

  always_comb begin
    req         = '0;
    req[GNT_LK] = bus.lk_valid & run;
    req[GNT_WR] = bus.wr_valid & run;
  end

  tag_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  assign bus.lk_ready = run & gnt[GNT_LK];
  assign bus.wr_ready = run & gnt[GNT_WR];
  assign lk_acc       = bus.lk_valid & bus.lk_ready;
  assign wr_acc       = bus.wr_valid & bus.wr_ready;

  // SRAM port is driven in the accept cycle so the access lands on the same
  // edge that accepts it. reset_n gates the sweep's write enable so the port
  // is quiet while reset is held.
  always_comb begin
    sram_we_c   = 1'b0;
    sram_addr_c = addr_q;
    sram_din_c  = '0;
    if (state == ST_INIT) begin
      sram_we_c   = reset_n;
      sram_addr_c = clr_idx[CACHE_SET_BITS-1:0];
    end else if (wr_acc) begin
      sram_we_c   = 1'b1;
      sram_addr_c = bus.wr_set;
      sram_din_c  = {~bus.wr_inval, bus.wr_tag};
    end else if (lk_acc) begin
      sram_addr_c = bus.lk_set;
    end
  end

  assign bus.sram_we   = sram_we_c;
  assign bus.sram_addr = sram_addr_c;
  assign bus.sram_din  = sram_din_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_INIT;
      clr_idx      <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      lk_tag_q     <= '0;
      addr_q       <= '0;
    end else begin
      addr_q       <= sram_addr_c;
      resp_valid_q <= lk_acc;
      if (lk_acc) begin
        lk_tag_q <= bus.lk_tag;
      end
      if (state == ST_INIT) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == (CACHE_SET_BITS+1)'(N-1)) begin
          state       <= ST_RUN;
          init_done_q <= 1'b1;
        end
      end
    end
  end

  // sram_dout arrives one cycle after the read, i.e. in the response cycle,
  // so the compare is combinational against the captured lookup tag.
  assign bus.lk_resp_valid = resp_valid_q;
  assign bus.lk_resp_tag   = resp_valid_q ? bus.sram_dout[CACHE_TAG_BITS-1:0] : '0;
  assign bus.lk_hit        = resp_valid_q & bus.sram_dout[VLD] &
                             (bus.sram_dout[CACHE_TAG_BITS-1:0] == lk_tag_q);
  assign bus.init_done     = init_done_q;
  assign dbg_state         = state;

endmodule
